fast_controls_gen: RTL and testbench
====================================

// Module: fast_controls_gen
// PURPOSE
//  Transmit end of the RJ-45 fast-control link: generates orbit-aligned QIE reset (active-low),
//  WTE and aux reset on behalf of the ngCCM emulator for a downstream fast-controls receiver.
//  Runs an orbit/BX counter and places each signal at a programmable BX, for a fixed number of
//  orbits or free-running. A software/board reset request drives a timed reset pulse and re-aligns the orbit.
// PARAMETERS
//  ORBIT_LEN   3564  BX per orbit (clk cycles); >= 2
//  QRST_WIDTH  4     qie_reset_n_out low cycles at BX 0; legal 1..16 (receiver holdoff is 16)
//  WTE_WIDTH   1     wte_out high cycles per orbit; >= 1
//  RST_WIDTH   40    reset_out high cycles per request; >= 1
// PORTS
//  clk              in   1   fast-control clock
//  reset_in         in   1   asynchronous, active-high reset
//  enable_in        in   1   1 = start/continue generating orbits
//  wte_bx_in        in   12  BX of first WTE cycle
//  n_orbits_in      in   16  orbits to generate; 0 = free-run
//  reset_req_in     in   1   rising edge requests an aux reset pulse
//  qie_reset_n_out  out  1   QIE reset to RJ-45, active-low
//  wte_out          out  1   WTE to RJ-45, active-high
//  reset_out        out  1   aux reset to RJ-45, active-high
//  bx_out           out  12  current BX
//  orbit_cnt_out    out  16  completed orbits, saturates at 16'hFFFF
//  busy_out         out  1   1 in RUN or RST
// BEHAVIOUR
//  - reset_in=1 (no clock needed): FSM=IDLE, qie_reset_n_out=1, wte_out=0, reset_out=0, bx_out=0,
//    orbit_cnt_out=0, busy_out=0, reset_req edge register=0. All outputs registered, glitch-free.
//  - FSM: IDLE, RUN, RST, DONE. Outputs decoded from next-state values so they align with bx_out.
//  - IDLE: idle outputs. enable_in=1 sampled at edge k -> RUN from edge k; first RUN cycle bx_out=0,
//    qie_reset_n_out=0. Latch n_orbits_in and wte_bx_in on this transition.
//  - RUN: bx_out +1 per clk; ORBIT_LEN-1 wraps to 0 and orbit_cnt_out +1 (saturating).
//    qie_reset_n_out=0 iff bx_out < QRST_WIDTH. wte_out=1 iff wte_bx <= bx_out < wte_bx+WTE_WIDTH,
//    truncated at ORBIT_LEN-1 (never wraps into next orbit); wte_bx >= ORBIT_LEN -> no WTE.
//    wte_bx_in re-latched only at the wrap cycle; mid-orbit changes take effect next orbit.
//  - RUN exit at wrap only (no truncated orbits): if latched n_orbits!=0 and completed orbits==n -> DONE;
//    else if enable_in=0 -> IDLE. Otherwise continue with bx_out=0.
//  - DONE: idle outputs, busy_out=0, orbit_cnt_out held; enable_in=0 -> IDLE (orbit_cnt_out cleared).
//  - reset_req_in rising edge (vs. 1-cycle delayed copy) in IDLE/RUN/DONE -> RST immediately,
//    aborting the orbit: reset_out=1 for exactly RST_WIDTH cycles, qie_reset_n_out=1, wte_out=0,
//    bx_out=0, orbit_cnt_out=0. Edges during RST ignored. After RST: enable_in=1 -> RUN at BX 0
//    (fresh latch of n_orbits/wte_bx), else IDLE.
//  - Same-cycle enable_in rise and reset_req edge: RST wins. Level-held reset_req_in = one pulse.
//  - One qie_reset_n low window per orbit -> receiver emits exactly one qie_reset pulse per orbit.
// TESTING
//  1. ORBIT_LEN=20, enable=1, n=0 -> qie_reset_n_out low BX 0..3 every 20 clk; orbit_cnt 1,2,3 at wraps.
//  2. wte_bx=7 -> wte_out high only at BX 7; set wte_bx=10 at BX 12 -> next orbit BX 10, current unchanged.
//  3. n_orbits=3 -> exactly 3 QRST windows, then DONE, busy_out=0, orbit_cnt_out=3; enable=0 -> IDLE, cnt 0.
//  4. reset_req rise at BX 9 -> reset_out high 40 clk, qie_reset_n=1, wte=0; then BX 0 with qie_reset_n=0.
//  5. reset_in asserted mid-RUN between edges -> all outputs idle values immediately; held req gives 1 pulse.
//  6. ORBIT_LEN=20, WTE_WIDTH=4, wte_bx=18 -> wte high BX 18,19 only; wte_bx=25 -> wte_out never high.

Source files
------------

// File: rtl/fast_controls_gen_if.sv
// ---------------------------------------------------------------------------
// fast_controls_gen_if
//   Control/status bundle of the fast-control link generator.
//   master : the controller side (drives enable/BX/orbit/reset-request,
//            observes the RJ-45 lines and status)
//   slave  : the generator itself (fast_controls_gen)
//   Signals:
//     enable_in        1 = start/continue generating orbits
//     wte_bx_in        BX of the first WTE cycle
//     n_orbits_in      orbits to generate, 0 = free-run
//     reset_req_in     rising edge requests an aux reset pulse
//     qie_reset_n_out  QIE reset, active-low
//     wte_out          WTE, active-high
//     reset_out        aux reset, active-high
//     bx_out           current BX
//     orbit_cnt_out    completed orbits (saturating)
//     busy_out         generator in RUN or RST
// ---------------------------------------------------------------------------
interface fast_controls_gen_if;
    logic        enable_in;
    logic [11:0] wte_bx_in;
    logic [15:0] n_orbits_in;
    logic        reset_req_in;
    logic        qie_reset_n_out;
    logic        wte_out;
    logic        reset_out;
    logic [11:0] bx_out;
    logic [15:0] orbit_cnt_out;
    logic        busy_out;

    modport master (
        output enable_in, wte_bx_in, n_orbits_in, reset_req_in,
        input  qie_reset_n_out, wte_out, reset_out, bx_out, orbit_cnt_out, busy_out
    );

    modport slave (
        input  enable_in, wte_bx_in, n_orbits_in, reset_req_in,
        output qie_reset_n_out, wte_out, reset_out, bx_out, orbit_cnt_out, busy_out
    );
endinterface

// File: rtl/fast_controls_gen.sv
// ---------------------------------------------------------------------------
// fast_controls_gen
//   Transmit end of the RJ-45 fast-control link. Runs a BX/orbit counter and
//   places QIE reset (active-low, BX 0..QRST_WIDTH-1), WTE (programmable BX)
//   and a timed aux reset pulse, for a fixed number of orbits or free-running.
//   Ports:
//     clk       fast-control clock
//     reset_in  asynchronous active-high reset
//     fc        fast_controls_gen_if.slave (control inputs, link outputs)
// ---------------------------------------------------------------------------
module fast_controls_gen #(
    parameter int unsigned ORBIT_LEN  = 3564,
    parameter int unsigned QRST_WIDTH = 4,
    parameter int unsigned WTE_WIDTH  = 1,
    parameter int unsigned RST_WIDTH  = 40
) (
    input  logic                 clk,
    input  logic                 reset_in,
    fast_controls_gen_if.slave   fc
);

    localparam int unsigned RCW = (RST_WIDTH > 1) ? $clog2(RST_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, RST, DONE} state_t;

    state_t          state, state_n;
    logic [11:0]     bx, bx_n;
    logic [15:0]     orbit_cnt, orbit_cnt_n;
    logic [15:0]     n_lat, n_lat_n;
    logic [11:0]     wte_lat, wte_lat_n;
    logic [RCW-1:0]  rst_cnt, rst_cnt_n;
    logic            req_d;
    logic            req_edge;
    logic            wrap;
    logic            qie_n_n, wte_n, rst_out_n, busy_n;

    assign req_edge = fc.reset_req_in & ~req_d;
    assign wrap     = (bx == 12'(ORBIT_LEN - 1));

    always_comb begin
        state_n     = state;
        bx_n        = bx;
        orbit_cnt_n = orbit_cnt;
        n_lat_n     = n_lat;
        wte_lat_n   = wte_lat;
        rst_cnt_n   = rst_cnt;

        // A reset request aborts everything except an ongoing RST.
        if (req_edge && state != RST) begin
            state_n     = RST;
            bx_n        = '0;
            orbit_cnt_n = '0;
            rst_cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fc.enable_in) begin
                        state_n     = RUN;
                        bx_n        = '0;
                        orbit_cnt_n = '0;
                        n_lat_n     = fc.n_orbits_in;
                        wte_lat_n   = fc.wte_bx_in;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        bx_n        = '0;
                        orbit_cnt_n = (orbit_cnt == '1) ? orbit_cnt : orbit_cnt + 16'd1;
                        wte_lat_n   = fc.wte_bx_in;
                        if (n_lat != '0 && orbit_cnt_n == n_lat) begin
                            state_n = DONE;
                        end else if (!fc.enable_in) begin
                            state_n     = IDLE;
                            orbit_cnt_n = '0;
                        end
                    end else begin
                        bx_n = bx + 12'd1;
                    end
                end
                RST: begin
                    if (rst_cnt == RCW'(RST_WIDTH - 1)) begin
                        bx_n        = '0;
                        orbit_cnt_n = '0;
                        if (fc.enable_in) begin
                            state_n   = RUN;
                            n_lat_n   = fc.n_orbits_in;
                            wte_lat_n = fc.wte_bx_in;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        rst_cnt_n = rst_cnt + RCW'(1);
                    end
                end
                DONE: begin
                    if (!fc.enable_in) begin
                        state_n     = IDLE;
                        orbit_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output decode from next-state values so the registered lines align
    // with the registered bx_out. bx_n never exceeds ORBIT_LEN-1, so the
    // WTE window is naturally truncated at the orbit end and a start BX
    // beyond the orbit never matches.
    always_comb begin
        qie_n_n   = 1'b1;
        wte_n     = 1'b0;
        rst_out_n = (state_n == RST);
        busy_n    = (state_n == RUN) || (state_n == RST);
        if (state_n == RUN) begin
            qie_n_n = !(32'(bx_n) < QRST_WIDTH);
            wte_n   = (32'(bx_n) >= 32'(wte_lat_n)) &&
                      (32'(bx_n) <  32'(wte_lat_n) + WTE_WIDTH);
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state              <= IDLE;
            bx                 <= '0;
            orbit_cnt          <= '0;
            n_lat              <= '0;
            wte_lat            <= '0;
            rst_cnt            <= '0;
            req_d              <= 1'b0;
            fc.qie_reset_n_out <= 1'b1;
            fc.wte_out         <= 1'b0;
            fc.reset_out       <= 1'b0;
            fc.busy_out        <= 1'b0;
        end else begin
            state              <= state_n;
            bx                 <= bx_n;
            orbit_cnt          <= orbit_cnt_n;
            n_lat              <= n_lat_n;
            wte_lat            <= wte_lat_n;
            rst_cnt            <= rst_cnt_n;
            req_d              <= fc.reset_req_in;
            fc.qie_reset_n_out <= qie_n_n;
            fc.wte_out         <= wte_n;
            fc.reset_out       <= rst_out_n;
            fc.busy_out        <= busy_n;
        end
    end

    assign fc.bx_out        = bx;
    assign fc.orbit_cnt_out = orbit_cnt;

endmodule

// File: tb/tb_fast_controls_gen.sv
// ---------------------------------------------------------------------------
// tb_fast_controls_gen
//   Directed bench for fast_controls_gen. Instance a: ORBIT_LEN=20,
//   QRST_WIDTH=4, WTE_WIDTH=1, RST_WIDTH=40. Instance b: same but WTE_WIDTH=4.
// ---------------------------------------------------------------------------
module tb_fast_controls_gen;

    logic clk = 1'b0;
    logic reset_in;
    int   n_cmp = 0;
    int   n_err = 0;
    int   low_cnt;
    int   win_cnt;
    logic prev_qie;

    always #5 clk = ~clk;

    fast_controls_gen_if ifa ();
    fast_controls_gen_if ifb ();

    fast_controls_gen #(
        .ORBIT_LEN(20), .QRST_WIDTH(4), .WTE_WIDTH(1), .RST_WIDTH(40)
    ) dut_a (
        .clk(clk), .reset_in(reset_in), .fc(ifa)
    );

    fast_controls_gen #(
        .ORBIT_LEN(20), .QRST_WIDTH(4), .WTE_WIDTH(4), .RST_WIDTH(40)
    ) dut_b (
        .clk(clk), .reset_in(reset_in), .fc(ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_qie"},  32'(ifa.qie_reset_n_out), 32'd1);
        chk({tag, "_wte"},  32'(ifa.wte_out),         32'd0);
        chk({tag, "_rst"},  32'(ifa.reset_out),       32'd0);
        chk({tag, "_bx"},   32'(ifa.bx_out),          32'd0);
        chk({tag, "_cnt"},  32'(ifa.orbit_cnt_out),   32'd0);
        chk({tag, "_busy"}, 32'(ifa.busy_out),        32'd0);
    endtask

    initial begin
        reset_in         = 1'b1;
        ifa.enable_in    = 1'b0;
        ifa.wte_bx_in    = 12'd7;
        ifa.n_orbits_in  = 16'd0;
        ifa.reset_req_in = 1'b0;
        ifb.enable_in    = 1'b0;
        ifb.wte_bx_in    = 12'd18;
        ifb.n_orbits_in  = 16'd0;
        ifb.reset_req_in = 1'b0;
        #2;
        chk_idle_a("reset");

        // Test 1/2: free-run, QRST BX 0..3, WTE at BX 7
        tick();
        reset_in      = 1'b0;
        ifa.enable_in = 1'b1;
        tick();
        chk("start_bx",   32'(ifa.bx_out),          32'd0);
        chk("start_qie",  32'(ifa.qie_reset_n_out), 32'd0);
        chk("start_busy", 32'(ifa.busy_out),        32'd1);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("o1_bx",  32'(ifa.bx_out),          32'(i));
            chk("o1_qie", 32'(ifa.qie_reset_n_out), 32'(i >= 4));
            chk("o1_wte", 32'(ifa.wte_out),         32'(i == 7));
        end
        tick();
        chk("wrap1_bx",  32'(ifa.bx_out),          32'd0);
        chk("wrap1_cnt", 32'(ifa.orbit_cnt_out),   32'd1);
        chk("wrap1_qie", 32'(ifa.qie_reset_n_out), 32'd0);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("o2_wte", 32'(ifa.wte_out), 32'(i == 7));
            if (i == 12) ifa.wte_bx_in = 12'd10;
        end
        tick();
        chk("wrap2_cnt", 32'(ifa.orbit_cnt_out), 32'd2);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("o3_wte", 32'(ifa.wte_out), 32'(i == 10));
        end
        tick();
        chk("wrap3_cnt", 32'(ifa.orbit_cnt_out), 32'd3);

        // Test 4: reset request at BX 9, held high afterwards
        for (int i = 1; i < 10; i++) tick();
        chk("pre_req_bx", 32'(ifa.bx_out), 32'd9);
        ifa.reset_req_in = 1'b1;
        tick();
        chk("rst_out",  32'(ifa.reset_out),       32'd1);
        chk("rst_qie",  32'(ifa.qie_reset_n_out), 32'd1);
        chk("rst_wte",  32'(ifa.wte_out),         32'd0);
        chk("rst_bx",   32'(ifa.bx_out),          32'd0);
        chk("rst_cnt",  32'(ifa.orbit_cnt_out),   32'd0);
        chk("rst_busy", 32'(ifa.busy_out),        32'd1);
        for (int i = 2; i <= 40; i++) begin
            tick();
            chk("rst_hold", 32'(ifa.reset_out), 32'd1);
        end
        tick();
        chk("post_rst_out",  32'(ifa.reset_out),       32'd0);
        chk("post_rst_bx",   32'(ifa.bx_out),          32'd0);
        chk("post_rst_qie",  32'(ifa.qie_reset_n_out), 32'd0);
        chk("post_rst_busy", 32'(ifa.busy_out),        32'd1);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("held_req_rst", 32'(ifa.reset_out), 32'd0);
            chk("held_req_bx",  32'(ifa.bx_out),    32'(i));
        end
        ifa.reset_req_in = 1'b0;
        tick();
        chk("post_rst_wrap_cnt", 32'(ifa.orbit_cnt_out), 32'd1);

        // enable drop mid-orbit: finish the orbit, then IDLE
        ifa.enable_in = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("drain_busy", 32'(ifa.busy_out), 32'd1);
        end
        tick();
        chk_idle_a("to_idle");

        // Test 3: three orbits then DONE
        ifa.n_orbits_in = 16'd3;
        ifa.enable_in   = 1'b1;
        tick();
        chk("n3_qie", 32'(ifa.qie_reset_n_out), 32'd0);
        low_cnt  = 1;
        win_cnt  = 1;
        prev_qie = 1'b0;
        for (int i = 1; i < 60; i++) begin
            tick();
            chk("n3_busy", 32'(ifa.busy_out), 32'd1);
            if (ifa.qie_reset_n_out == 1'b0) begin
                low_cnt++;
                if (prev_qie) win_cnt++;
            end
            prev_qie = ifa.qie_reset_n_out;
        end
        tick();
        chk("done_busy", 32'(ifa.busy_out),        32'd0);
        chk("done_cnt",  32'(ifa.orbit_cnt_out),   32'd3);
        chk("done_qie",  32'(ifa.qie_reset_n_out), 32'd1);
        chk("done_bx",   32'(ifa.bx_out),          32'd0);
        chk("n3_windows", 32'(win_cnt), 32'd3);
        chk("n3_low_cycles", 32'(low_cnt), 32'd12);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("done_stay_busy", 32'(ifa.busy_out),      32'd0);
            chk("done_stay_cnt",  32'(ifa.orbit_cnt_out), 32'd3);
        end
        ifa.enable_in = 1'b0;
        tick();
        chk_idle_a("done_to_idle");

        // Test 5: async reset mid-RUN, held request gives one pulse
        ifa.n_orbits_in = 16'd0;
        ifa.enable_in   = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_async_bx", 32'(ifa.bx_out), 32'd5);
        #3;
        reset_in = 1'b1;
        ifa.reset_req_in = 1'b1;
        #1;
        chk_idle_a("async");
        tick();
        chk_idle_a("async_hold");
        reset_in = 1'b0;
        tick();
        chk("req_win_rst",  32'(ifa.reset_out),       32'd1);
        chk("req_win_qie",  32'(ifa.qie_reset_n_out), 32'd1);
        chk("req_win_busy", 32'(ifa.busy_out),        32'd1);
        for (int i = 2; i <= 40; i++) tick();
        chk("req_win_last", 32'(ifa.reset_out), 32'd1);
        tick();
        chk("after_req_rst", 32'(ifa.reset_out),       32'd0);
        chk("after_req_qie", 32'(ifa.qie_reset_n_out), 32'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("one_pulse", 32'(ifa.reset_out), 32'd0);
        end
        ifa.reset_req_in = 1'b0;
        ifa.enable_in    = 1'b0;

        // Test 6: WTE_WIDTH=4 truncated at orbit end; out-of-orbit start BX
        ifb.enable_in = 1'b1;
        tick();
        chk("b_start_bx",  32'(ifb.bx_out),  32'd0);
        chk("b_start_wte", 32'(ifb.wte_out), 32'd0);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("b_o1_wte", 32'(ifb.wte_out), 32'(i >= 18));
        end
        tick();
        chk("b_wrap_bx",  32'(ifb.bx_out),  32'd0);
        chk("b_wrap_wte", 32'(ifb.wte_out), 32'd0);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("b_o2_wte", 32'(ifb.wte_out), 32'(i >= 18));
            if (i == 5) ifb.wte_bx_in = 12'd25;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("b_o3_wte", 32'(ifb.wte_out), 32'd0);
        end
        chk("b_o3_bx", 32'(ifb.bx_out), 32'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
